// File: rtl/add_seq_pkg.sv
// Shared types and lane masks for the nibble-serial packed adder.
// Every lane-layout decision in add_seq is made through the two mask functions.
package add_seq_pkg;

    localparam int DATA_W = 16;
    localparam int NIB_N  = 4;

    typedef enum logic [1:0] {
        W4     = 2'b00,
        W8     = 2'b01,
        W16    = 2'b10,
        W8_ALT = 2'b11
    } bitnum_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Bit k of each mask refers to nibble k.
    localparam logic [NIB_N-1:0] START_W4  = 4'b1111;
    localparam logic [NIB_N-1:0] START_W8  = 4'b0101;
    localparam logic [NIB_N-1:0] START_W16 = 4'b0001;
    localparam logic [NIB_N-1:0] MSB_W4    = 4'b1111;
    localparam logic [NIB_N-1:0] MSB_W8    = 4'b1010;
    localparam logic [NIB_N-1:0] MSB_W16   = 4'b1000;

    // Nibbles that begin a lane and therefore take a zero carry-in.
    function automatic logic [NIB_N-1:0] lane_start_mask(input bitnum_e bn);
        case (bn)
            W4:      return START_W4;
            W16:     return START_W16;
            default: return START_W8;
        endcase
    endfunction

    // Nibbles that end a lane and therefore report a carry-out flag.
    function automatic logic [NIB_N-1:0] lane_msb_mask(input bitnum_e bn);
        case (bn)
            W4:      return MSB_W4;
            W16:     return MSB_W16;
            default: return MSB_W8;
        endcase
    endfunction

endpackage

// File: rtl/add_seq_nib_add.sv
// 4-bit adder with carry-in; add_seq uses one instance for every nibble.
module nib_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/add_seq.sv
// Packed lane adder that processes one nibble per clock through a shared nib_add.
// Lanes are 4, 8 or 16 bits wide; carries never cross a lane boundary.
module add_seq
    import add_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_W-1:0]    dataA,
    input  logic [DATA_W-1:0]    dataB,
    input  logic [1:0]           bitnum,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_W-1:0]    sum,
    output logic [NIB_N-1:0]     cout
);

    state_e              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    bitnum_e             bn_q, bn_d;
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic [NIB_N-1:0]    cout_q, cout_d;
    logic                carry_q, carry_d;

    logic [3:0]          nib_base;
    logic [3:0]          nib_a, nib_b, nib_s;
    logic                nib_cin, nib_co;
    logic [NIB_N-1:0]    start_mask, msb_mask;

    assign nib_base   = {cnt_q, 2'b00};
    assign nib_a      = a_q[nib_base +: 4];
    assign nib_b      = b_q[nib_base +: 4];
    assign start_mask = lane_start_mask(bn_q);
    assign msb_mask   = lane_msb_mask(bn_q);
    // A lane-start nibble ignores the stored carry, so no carry leaks across lanes.
    assign nib_cin    = start_mask[cnt_q] ? 1'b0 : carry_q;

    nib_add u_nib_add (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (nib_cin),
        .s    (nib_s),
        .cout (nib_co)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        bn_d    = bn_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        carry_d = carry_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = 2'd0;
                    a_d     = dataA;
                    b_d     = dataB;
                    bn_d    = bitnum_e'(bitnum);
                    sum_d   = '0;
                    cout_d  = '0;
                    carry_d = 1'b0;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[nib_base +: 4] = nib_s;
                cout_d[cnt_q]        = msb_mask[cnt_q] & nib_co;
                carry_d              = nib_co;
                cnt_d                = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            a_q     <= '0;
            b_q     <= '0;
            bn_q    <= W4;
            sum_q   <= '0;
            cout_q  <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            bn_q    <= bn_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            carry_q <= carry_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
